// File: rtl/zrle_pkg.sv
// Shared types and constants for the zero-run-length stream decoder.
package zrle_pkg;
    typedef enum logic [1:0] {
        S_LIT = 2'd0,   // pass literals, watch for escape
        S_LEN = 2'd1,   // escape seen, waiting for run length
        S_RUN = 2'd2    // emitting zeros
    } state_t;

    localparam logic [7:0] ESC_DEFAULT = 8'h00;
    localparam int         ERR_ZLEN    = 0;   // escape followed by length 0
    localparam int         ERR_TRUNC   = 1;   // frame ended right after escape
endpackage

// File: rtl/zrle_out_reg.sv
// One-entry output holding register with valid/ready. Contents stay frozen
// while the consumer stalls; a new byte may load whenever the slot is free.
module zrle_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] ld_data,
    input  logic         ld_last,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    output logic         slot_free
);
    logic [W-1:0] data_q, data_d;
    logic         last_q, last_d;
    logic         valid_q, valid_d;

    assign slot_free = !valid_q || out_ready;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

    // Load on a free slot, otherwise drop valid once the consumer takes the byte.
    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load && slot_free) begin
            data_d  = ld_data;
            last_d  = ld_last;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: rtl/zrle_stream_decoder.sv
// Streaming zero-run-length decoder: literals pass through, ESC,N expands to
// N zero bytes. Optional per-kind output statistics under ZRLE_STATS_EN.
module zrle_stream_decoder
    import zrle_pkg::*;
#(
    parameter logic [7:0] ESC = ESC_DEFAULT
`ifdef ZRLE_STATS_EN
   ,parameter int STAT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [1:0]  err
`ifdef ZRLE_STATS_EN
   ,output logic [STAT_W-1:0] lit_count,
    output logic [STAT_W-1:0] zero_count
`endif
);
    state_t      state_q, state_d;
    logic [7:0]  run_cnt_q, run_cnt_d;
    logic        last_pend_q, last_pend_d;
    logic [1:0]  err_q, err_d;

    logic        slot_free;
    logic        load;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_lit;

    zrle_out_reg #(.W(8)) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .slot_free (slot_free)
    );

    assign err = err_q;

    // FSM next state, run counter, error flags and output-register load.
    // A zero-length run that also ends the frame produces nothing; any byte
    // still stalled in the output register drains normally.
    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        last_pend_d = last_pend_q;
        err_d       = err_q;
        in_ready    = 1'b0;
        load        = 1'b0;
        ld_data     = 8'h00;
        ld_last     = 1'b0;
        ld_lit      = 1'b0;
        case (state_q)
            S_LIT: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    if (in_data != ESC) begin
                        load    = 1'b1;
                        ld_data = in_data;
                        ld_last = in_last;
                        ld_lit  = 1'b1;
                    end else if (in_last) begin
                        err_d[ERR_TRUNC] = 1'b1;
                    end else begin
                        state_d = S_LEN;
                    end
                end
            end
            S_LEN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data == 8'h00) begin
                        err_d[ERR_ZLEN] = 1'b1;
                        state_d         = S_LIT;
                    end else begin
                        run_cnt_d   = in_data;
                        last_pend_d = in_last;
                        state_d     = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (slot_free) begin
                    load      = 1'b1;
                    run_cnt_d = run_cnt_q - 8'd1;
                    if (run_cnt_q == 8'd1) begin
                        ld_last = last_pend_q;
                        state_d = S_LIT;
                    end
                end
            end
            default: state_d = S_LIT;
        endcase
    end

    // Decoder state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LIT;
            run_cnt_q   <= 8'd0;
            last_pend_q <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            last_pend_q <= last_pend_d;
            err_q       <= err_d;
        end
    end

`ifdef ZRLE_STATS_EN
    // Tag of the byte in the output register, so each handshake is counted
    // by kind (a literal may equal zero when ESC is non-zero).
    logic              lit_q, lit_d;
    logic [STAT_W-1:0] lit_count_q, lit_count_d;
    logic [STAT_W-1:0] zero_count_q, zero_count_d;
    logic              hs;

    assign hs         = out_valid && out_ready;
    assign lit_count  = lit_count_q;
    assign zero_count = zero_count_q;

    // Count output handshakes per byte kind; counters wrap naturally.
    always_comb begin
        lit_d        = lit_q;
        lit_count_d  = lit_count_q;
        zero_count_d = zero_count_q;
        if (hs && lit_q)  lit_count_d  = lit_count_q + 1'b1;
        if (hs && !lit_q) zero_count_d = zero_count_q + 1'b1;
        if (load && slot_free) lit_d = ld_lit;
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lit_q        <= 1'b0;
            lit_count_q  <= '0;
            zero_count_q <= '0;
        end else begin
            lit_q        <= lit_d;
            lit_count_q  <= lit_count_d;
            zero_count_q <= zero_count_d;
        end
    end
`endif
endmodule
